// File: rtl/memory_bus_if.sv
// Data-memory request/ready bus between the memory stage and data memory.
// Address, write data and write enable are valid while req is high.
interface memory_bus_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ready;
  logic [15:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/memory_stage.sv
// MEM pipeline stage: variable-latency data-memory access with stall,
// timeout abort and the MEM/WB pipeline register.
module memory_stage #(
  parameter int          TIMEOUT  = 16,
  parameter logic [15:0] ERR_DATA = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        iAluOut,
  input  logic [15:0]        iData2,
  input  logic               iMemRead,
  input  logic               iMemWrite,
  input  logic               iAlutoReg,
  input  logic               iMemtoReg,
  input  logic               iBustoReg,
  input  logic [3:0]         iDest,
  input  logic [15:0]        iBusData,
  memory_bus_if.master       mem,
  output logic               oStall,
  output logic [15:0]        oWriteBackData,
  output logic               oRegWrite,
  output logic [3:0]         oDest,
  output logic               oMemErr
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   wb_q, wb_d;
  logic          rw_q, rw_d;
  logic [3:0]    dest_q, dest_d;
  logic          err_q, err_d;
  logic          hold_en;

  logic [15:0] addr_q, wdata_q, bus_q;
  logic        wr_q, rd_q, m2r_q, a2r_q, b2r_q;
  logic [3:0]  hdest_q;

  logic        in_wait, acc, tmo;
  logic [15:0] c_addr, c_wdata, c_bus;
  logic        c_wr, c_rd, c_m2r, c_a2r, c_b2r;
  logic [3:0]  c_dest;
  logic [15:0] rsel, mux_val, res;
  logic        res_rw;

  assign in_wait = (state_q == S_WAIT);
  assign acc     = iMemRead | iMemWrite;
  assign tmo     = in_wait & (cnt_q == TMAX);

  // While waiting, execute inputs are ignored; everything comes from hold regs.
  assign c_addr  = in_wait ? addr_q  : iAluOut;
  assign c_wdata = in_wait ? wdata_q : iData2;
  assign c_bus   = in_wait ? bus_q   : iBusData;
  assign c_wr    = in_wait ? wr_q    : iMemWrite;
  assign c_rd    = in_wait ? rd_q    : (iMemRead & ~iMemWrite);
  assign c_m2r   = in_wait ? m2r_q   : iMemtoReg;
  assign c_a2r   = in_wait ? a2r_q   : iAlutoReg;
  assign c_b2r   = in_wait ? b2r_q   : iBustoReg;
  assign c_dest  = in_wait ? hdest_q : iDest;

  assign rsel    = mem.ready ? mem.rdata : ERR_DATA;
  assign mux_val = c_b2r ? c_bus : c_addr;
  assign res     = c_m2r ? (c_rd ? rsel : ERR_DATA) : mux_val;
  assign res_rw  = c_a2r | c_b2r | (c_rd & c_m2r);

  assign mem.req   = ~rst & (in_wait | acc);
  assign mem.we    = c_wr;
  assign mem.addr  = c_addr;
  assign mem.wdata = c_wdata;

  assign oStall = ~rst & mem.req & ~mem.ready & ~tmo;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wb_d    = wb_q;
    rw_d    = 1'b0;
    dest_d  = dest_q;
    err_d   = 1'b0;
    hold_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!acc) begin
          wb_d   = mux_val;
          rw_d   = iAlutoReg | iBustoReg;
          dest_d = iDest;
        end else if (mem.ready) begin
          wb_d   = res;
          rw_d   = res_rw;
          dest_d = c_dest;
        end else begin
          hold_en = 1'b1;
          state_d = S_WAIT;
          cnt_d   = CW'(1);
        end
      end
      S_WAIT: begin
        if (mem.ready || tmo) begin
          wb_d    = res;
          rw_d    = res_rw;
          dest_d  = c_dest;
          err_d   = ~mem.ready;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
      rw_q    <= 1'b0;
      dest_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bus_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      m2r_q   <= 1'b0;
      a2r_q   <= 1'b0;
      b2r_q   <= 1'b0;
      hdest_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      rw_q    <= rw_d;
      dest_q  <= dest_d;
      err_q   <= err_d;
      if (hold_en) begin
        addr_q  <= iAluOut;
        wdata_q <= iData2;
        bus_q   <= iBusData;
        wr_q    <= iMemWrite;
        rd_q    <= iMemRead & ~iMemWrite;
        m2r_q   <= iMemtoReg;
        a2r_q   <= iAlutoReg;
        b2r_q   <= iBustoReg;
        hdest_q <= iDest;
      end
    end
  end

  assign oWriteBackData = wb_q;
  assign oRegWrite      = rw_q;
  assign oDest          = dest_q;
  assign oMemErr        = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: single-cycle vector table plus
// hand-written wait-state, timeout and reset sequences.
module tb_memory_stage;

  localparam logic [15:0] ERR = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu, d2, bus;
  logic        rd, wr, a2r, m2r, b2r;
  logic [3:0]  dest;
  logic        stall, rw, err;
  logic [15:0] wb;
  logic [3:0]  odest;

  int n_chk = 0;
  int n_fail = 0;

  memory_bus_if bus_if ();

  memory_stage #(.TIMEOUT(4), .ERR_DATA(ERR)) dut (
    .clk            (clk),
    .rst            (rst),
    .iAluOut        (alu),
    .iData2         (d2),
    .iMemRead       (rd),
    .iMemWrite      (wr),
    .iAlutoReg      (a2r),
    .iMemtoReg      (m2r),
    .iBustoReg      (b2r),
    .iDest          (dest),
    .iBusData       (bus),
    .mem            (bus_if),
    .oStall         (stall),
    .oWriteBackData (wb),
    .oRegWrite      (rw),
    .oDest          (odest),
    .oMemErr        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] alu;
    logic [15:0] d2;
    logic        rd, wr, a2r, m2r, b2r;
    logic [3:0]  dest;
    logic [15:0] bus;
    logic        rdy;
    logic [15:0] rdat;
    logic        e_req, e_we, e_stall;
    logic [15:0] e_wb;
    logic        e_rw;
    logic [3:0]  e_dest;
  } vec_t;

  vec_t v [8];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    alu = 16'h0; d2 = 16'h0; bus = 16'h0;
    rd = 1'b0; wr = 1'b0; a2r = 1'b0; m2r = 1'b0; b2r = 1'b0;
    dest = 4'd0;
    bus_if.ready = 1'b0; bus_if.rdata = 16'h0;
  endtask

  task automatic load_in(input logic [15:0] a, input logic [3:0] d);
    idle_in();
    alu = a; rd = 1'b1; m2r = 1'b1; dest = d;
  endtask

  // Drive a pending timed-out load; ready optionally arrives on the last cycle.
  task automatic timeout_seq(input logic [15:0] a, input logic [3:0] d,
                             input logic last_rdy, input logic [15:0] rdat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) load_in(a, d);
      if (c == 4 && last_rdy) begin
        bus_if.ready = 1'b1; bus_if.rdata = rdat;
      end
      #1;
      chk($sformatf("to_req%0d", c), 16'(bus_if.req), 16'd1);
      chk($sformatf("to_addr%0d", c), bus_if.addr, a);
      chk($sformatf("to_stall%0d", c), 16'(stall), (c == 4) ? 16'd0 : 16'd1);
      @(posedge clk); #1;
      if (c < 4) begin
        chk($sformatf("to_bubble%0d", c), 16'(rw), 16'd0);
        chk($sformatf("to_err%0d", c), 16'(err), 16'd0);
      end
    end
    chk("to_wb", wb, last_rdy ? rdat : ERR);
    chk("to_rw", 16'(rw), 16'd1);
    chk("to_dest", 16'(odest), 16'(d));
    chk("to_errpulse", 16'(err), last_rdy ? 16'd0 : 16'd1);
    @(negedge clk);
    idle_in();
    #1;
    chk("to_req_drop", 16'(bus_if.req), 16'd0);
    @(posedge clk); #1;
    chk("to_err_clr", 16'(err), 16'd0);
  endtask

  initial begin
    v[0] = '{16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3,
             16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 4'd3};
    v[1] = '{16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5,
             16'h7777, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h7777, 1'b1, 4'd5};
    v[2] = '{16'h0ABC, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6,
             16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0ABC, 1'b0, 4'd6};
    v[3] = '{16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1,
             16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 4'd1};
    v[4] = '{16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7,
             16'h0000, 1'b1, 16'h1357, 1'b1, 1'b0, 1'b0, 16'h1357, 1'b1, 4'd7};
    v[5] = '{16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2,
             16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0010, 1'b0, 4'd2};
    v[6] = '{16'h0030, 16'h5A5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4,
             16'h0000, 1'b1, 16'h9999, 1'b1, 1'b1, 1'b0, ERR,      1'b0, 4'd4};
    v[7] = '{16'h0044, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8,
             16'h0000, 1'b1, 16'h2468, 1'b1, 1'b0, 1'b0, 16'h2468, 1'b1, 4'd8};

    // Reset with a pending read request
    idle_in();
    rst = 1'b1; rd = 1'b1; alu = 16'h0040;
    #1;
    chk("rst_req", 16'(bus_if.req), 16'd0);
    chk("rst_stall", 16'(stall), 16'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_wb", wb, 16'h0);
    chk("rst_rw", 16'(rw), 16'd0);
    chk("rst_dest", 16'(odest), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_in();

    foreach (v[i]) begin
      @(negedge clk);
      alu = v[i].alu; d2 = v[i].d2; bus = v[i].bus;
      rd = v[i].rd; wr = v[i].wr;
      a2r = v[i].a2r; m2r = v[i].m2r; b2r = v[i].b2r;
      dest = v[i].dest;
      bus_if.ready = v[i].rdy; bus_if.rdata = v[i].rdat;
      #1;
      chk($sformatf("v%0d_req", i), 16'(bus_if.req), 16'(v[i].e_req));
      chk($sformatf("v%0d_stall", i), 16'(stall), 16'(v[i].e_stall));
      if (v[i].e_req) begin
        chk($sformatf("v%0d_we", i), 16'(bus_if.we), 16'(v[i].e_we));
        chk($sformatf("v%0d_addr", i), bus_if.addr, v[i].alu);
        chk($sformatf("v%0d_wdata", i), bus_if.wdata, v[i].d2);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_wb", i), wb, v[i].e_wb);
      chk($sformatf("v%0d_rw", i), 16'(rw), 16'(v[i].e_rw));
      chk($sformatf("v%0d_dest", i), 16'(odest), 16'(v[i].e_dest));
    end

    // Load with three wait cycles; execute inputs change underneath
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) load_in(16'h0040, 4'd9);
      else begin
        alu = 16'hFFFF; rd = 1'b0; wr = 1'b1; dest = 4'd15;
      end
      if (c == 3) begin
        bus_if.ready = 1'b1; bus_if.rdata = 16'hBEEF;
      end
      #1;
      chk($sformatf("ld_req%0d", c), 16'(bus_if.req), 16'd1);
      chk($sformatf("ld_addr%0d", c), bus_if.addr, 16'h0040);
      chk($sformatf("ld_we%0d", c), 16'(bus_if.we), 16'd0);
      chk($sformatf("ld_stall%0d", c), 16'(stall), (c == 3) ? 16'd0 : 16'd1);
      @(posedge clk); #1;
      if (c < 3) chk($sformatf("ld_bubble%0d", c), 16'(rw), 16'd0);
    end
    chk("ld_wb", wb, 16'hBEEF);
    chk("ld_rw", 16'(rw), 16'd1);
    chk("ld_dest", 16'(odest), 16'd9);
    chk("ld_err", 16'(err), 16'd0);

    timeout_seq(16'h0050, 4'd10, 1'b0, 16'h0000);
    timeout_seq(16'h0052, 4'd12, 1'b1, 16'h4242);

    // Back-to-back: second load sampled right after first completes
    @(negedge clk);
    load_in(16'h0070, 4'd13);
    @(posedge clk);
    @(negedge clk);
    bus_if.ready = 1'b1; bus_if.rdata = 16'h1111;
    @(posedge clk); #1;
    chk("b2b_wb1", wb, 16'h1111);
    @(negedge clk);
    load_in(16'h0072, 4'd14);
    bus_if.ready = 1'b1; bus_if.rdata = 16'h2222;
    #1;
    chk("b2b_req2", 16'(bus_if.req), 16'd1);
    chk("b2b_addr2", bus_if.addr, 16'h0072);
    @(posedge clk); #1;
    chk("b2b_wb2", wb, 16'h2222);
    chk("b2b_dest2", 16'(odest), 16'd14);

    // Reset in the second WAIT cycle abandons the access
    @(negedge clk);
    load_in(16'h0060, 4'd11);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("wrst_req", 16'(bus_if.req), 16'd0);
    chk("wrst_stall", 16'(stall), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    #1;
    chk("wrst_req_after", 16'(bus_if.req), 16'd0);
    chk("wrst_err", 16'(err), 16'd0);
    chk("wrst_rw", 16'(rw), 16'd0);
    chk("wrst_wb", wb, 16'h0);
    @(posedge clk); #1;
    chk("wrst_err2", 16'(err), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
